card_grid_renderer: RTL and testbench

- Parametrised successor of the single-card VGA renderer for the memory game.
- Draws an entire ROWS x COLS grid of cards from one block and keeps per-card state (down/up/matched) in registers.
- Runs a frame-timed horizontal "flip" animation driven by a command handshake from the game FSM.
- Sits between the VGA sync counter and the pixel mux; pixel path is pipelined against a synchronous sprite ROM.

---
 rtl/card_grid_renderer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_card_grid_renderer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_grid_renderer.sv
// card_grid_renderer: draws a ROWS x COLS grid of memory-game cards. It holds
// per-card state (DOWN/UP/MATCHED), runs a frame-timed horizontal flip
// animation on command, and produces pixels through a 2-stage pipeline that
// reads one sprite row per pixel from a synchronous ROM.
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid && cmd_ready. cmd_ready is simply !anim_busy, so nothing is
// accepted while a flip is running, and at most one command per cycle.
//
// Optional feature: define CARD_CURSOR_EN to add the cursor/cursor_on inputs
// and draw a 2-pixel highlight border around the selected card.
module card_grid_renderer #(
  parameter int COLS        = 4,
  parameter int ROWS        = 4,
  parameter int CARD_W      = 90,
  parameter int CARD_H      = 90,
  parameter int PITCH_X     = 100,
  parameter int PITCH_Y     = 100,
  parameter int ORIGIN_X    = 130,
  parameter int ORIGIN_Y    = 70,
  parameter int FLIP_FRAMES = 8,
  parameter logic [2:0] BACK_RGB  = 3'b100,
  parameter logic [2:0] MATCH_RGB = 3'b010
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  frame_start,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [3:0]            cmd_card,
  output logic [6:0]            rom_row,
  input  logic [CARD_W*3-1:0]   rom_data,
`ifdef CARD_CURSOR_EN
  input  logic [3:0]            cursor,
  input  logic                  cursor_on,
`endif
  output logic                  anim_busy,
  output logic                  cardon,
  output logic [2:0]            rgb
);

  localparam int NCARDS = COLS * ROWS;
  localparam int H      = FLIP_FRAMES / 2;
  localparam int STEP   = CARD_W / FLIP_FRAMES;
  localparam int CW     = (FLIP_FRAMES > 2) ? $clog2(FLIP_FRAMES) : 1;
  localparam int RB     = $clog2(CARD_W * 3);

  localparam logic [1:0] ST_DOWN    = 2'd0;
  localparam logic [1:0] ST_UP      = 2'd1;
  localparam logic [1:0] ST_MATCHED = 2'd2;

  localparam logic [1:0] OP_UP    = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_MATCH = 2'b10;
  localparam logic [1:0] OP_RESET = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(FLIP_FRAMES - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H);

  typedef enum logic {
    ANIM_IDLE = 1'b0,
    ANIM_RUN  = 1'b1
  } anim_state_t;

  anim_state_t   anim_state;
  logic [1:0]    card_state [16];
  logic [3:0]    anim_card;
  logic [CW-1:0] anim_cnt;
  logic [1:0]    anim_target;

  assign cmd_ready = ~anim_busy;

  // Command acceptance, card state updates and the flip animation FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_state  <= ANIM_IDLE;
      anim_busy   <= 1'b0;
      anim_card   <= 4'd0;
      anim_cnt    <= '0;
      anim_target <= ST_DOWN;
      for (int i = 0; i < 16; i++) card_state[i] <= ST_DOWN;
    end else begin
      case (anim_state)
        ANIM_IDLE: begin
          if (cmd_valid && int'(cmd_card) < NCARDS) begin
            case (cmd_op)
              OP_UP: begin
                if (card_state[cmd_card] == ST_DOWN) begin
                  anim_state  <= ANIM_RUN;
                  anim_busy   <= 1'b1;
                  anim_card   <= cmd_card;
                  anim_cnt    <= '0;
                  anim_target <= ST_UP;
                end
              end
              OP_DOWN: begin
                if (card_state[cmd_card] == ST_UP) begin
                  anim_state  <= ANIM_RUN;
                  anim_busy   <= 1'b1;
                  anim_card   <= cmd_card;
                  anim_cnt    <= '0;
                  anim_target <= ST_DOWN;
                end
              end
              OP_MATCH: begin
                if (card_state[cmd_card] == ST_UP) card_state[cmd_card] <= ST_MATCHED;
              end
              OP_RESET: begin
                for (int i = 0; i < 16; i++) card_state[i] <= ST_DOWN;
              end
              default: ;
            endcase
          end
        end
        ANIM_RUN: begin
          if (frame_start) begin
            if (anim_cnt == CNT_LAST) begin
              // Last animation frame: the card takes its new face now.
              card_state[anim_card] <= anim_target;
              anim_state <= ANIM_IDLE;
              anim_busy  <= 1'b0;
              anim_cnt   <= '0;
            end else begin
              anim_cnt <= anim_cnt + 1'b1;
            end
          end
        end
        default: begin
          anim_state <= ANIM_IDLE;
          anim_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: locate the pixel within the grid.
  // ---------------------------------------------------------------------
  logic       col_hit, row_hit;
  logic [3:0] col_sel, row_sel;
  logic [6:0] hx, vy;

  // Decode which card column/row the raw counters fall in, and local offsets.
  always_comb begin
    col_hit = 1'b0;
    row_hit = 1'b0;
    col_sel = 4'd0;
    row_sel = 4'd0;
    hx      = 7'd0;
    vy      = 7'd0;
    for (int c = 0; c < COLS; c++) begin
      if (hcount >= 10'(ORIGIN_X + c * PITCH_X) &&
          hcount <= 10'(ORIGIN_X + c * PITCH_X + CARD_W - 1)) begin
        col_hit = 1'b1;
        col_sel = 4'(c);
        hx      = 7'(hcount - 10'(ORIGIN_X + c * PITCH_X));
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (vcount >= 10'(ORIGIN_Y + r * PITCH_Y) &&
          vcount <= 10'(ORIGIN_Y + r * PITCH_Y + CARD_H - 1)) begin
        row_hit = 1'b1;
        row_sel = 4'(r);
        vy      = 7'(vcount - 10'(ORIGIN_Y + r * PITCH_Y));
      end
    end
  end

  logic       s1_hit;
  logic [3:0] s1_idx;
  logic [6:0] s1_lx;
`ifdef CARD_CURSOR_EN
  logic [6:0] s1_ly;
  logic [3:0] s1_cursor;
  logic       s1_cursor_on;
`endif

  // Register the hit decode and issue the sprite row address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit  <= 1'b0;
      s1_idx  <= 4'd0;
      s1_lx   <= 7'd0;
      rom_row <= 7'd0;
`ifdef CARD_CURSOR_EN
      s1_ly        <= 7'd0;
      s1_cursor    <= 4'd0;
      s1_cursor_on <= 1'b0;
`endif
    end else begin
      s1_hit  <= col_hit && row_hit;
      s1_idx  <= 4'(int'(row_sel) * COLS + int'(col_sel));
      s1_lx   <= hx;
      rom_row <= (col_hit && row_hit) ? vy : 7'd0;
`ifdef CARD_CURSOR_EN
      s1_ly        <= vy;
      s1_cursor    <= cursor;
      s1_cursor_on <= cursor_on;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: colour select.
  // ---------------------------------------------------------------------
  logic [1:0]    shown_state;
  logic          in_window;
  logic [2:0]    face_rgb;
  logic [RB-1:0] pix_base;
  logic          nxt_cardon;
  logic [2:0]    nxt_rgb;
  int            fold;
  int            inset;

  // Pick the side to show and apply the flip crop for the animating card.
  always_comb begin
    shown_state = card_state[s1_idx];
    in_window   = 1'b1;
    fold        = 0;
    inset       = 0;
    if (anim_busy && s1_idx == anim_card) begin
      fold      = (anim_cnt < CNT_HALF) ? int'(anim_cnt) : FLIP_FRAMES - 1 - int'(anim_cnt);
      inset     = fold * STEP;
      in_window = (int'(s1_lx) >= inset) && (int'(s1_lx) <= CARD_W - 1 - inset);
      if (anim_cnt >= CNT_HALF) shown_state = anim_target;
    end
  end

  // Map the shown state to a colour; the sprite is cropped, never scaled.
  always_comb begin
    pix_base = RB'(s1_lx) * RB'(3);
    case (shown_state)
      ST_DOWN: face_rgb = BACK_RGB;
      ST_UP:   face_rgb = rom_data[pix_base +: 3];
      default: face_rgb = MATCH_RGB;
    endcase
    nxt_cardon = s1_hit && in_window;
    nxt_rgb    = nxt_cardon ? face_rgb : 3'b000;
`ifdef CARD_CURSOR_EN
    // Highlight border wins over the face colour but stays inside the crop.
    if (nxt_cardon && s1_cursor_on && s1_idx == s1_cursor &&
        (int'(s1_lx) < 2 || int'(s1_lx) > CARD_W - 3 ||
         int'(s1_ly) < 2 || int'(s1_ly) > CARD_H - 3)) begin
      nxt_rgb = 3'b110;
    end
`endif
  end

  // Register the final pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cardon <= 1'b0;
      rgb    <= 3'b000;
    end else begin
      cardon <= nxt_cardon;
      rgb    <= nxt_rgb;
    end
  end

endmodule

// File: tb/tb_card_grid_renderer.sv
// Bench for card_grid_renderer: directed steps from the memory-game plan
// followed by a randomized command/pixel phase, all checked against a
// behavioural model of the card grid.
module tb_card_grid_renderer;

  localparam int COLS = 4, ROWS = 4, CARD_W = 90, CARD_H = 90;
  localparam int PITCH_X = 100, PITCH_Y = 100, ORIGIN_X = 130, ORIGIN_Y = 70;
  localparam int FLIP_FRAMES = 8;
  localparam logic [2:0] BACK_RGB = 3'b100, MATCH_RGB = 3'b010;

  logic                 clk, rst_n;
  logic [9:0]           hcount, vcount;
  logic                 frame_start, cmd_valid, cmd_ready;
  logic [1:0]           cmd_op;
  logic [3:0]           cmd_card;
  logic [6:0]           rom_row;
  logic [CARD_W*3-1:0]  rom_pat;
  logic                 anim_busy, cardon;
  logic [2:0]           rgb;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: expected {cardon,rgb} per issued pixel, and its hcount.
  logic [3:0] exp_q[$];
  int         h_q[$];

  // Reference model state.
  int m_state [16];
  bit m_busy;
  int m_card, m_cnt, m_target;

  card_grid_renderer dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_card(cmd_card), .rom_row(rom_row), .rom_data(rom_pat),
    .anim_busy(anim_busy), .cardon(cardon), .rgb(rgb)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_state[i] = 0;
    m_busy = 0; m_cnt = 0; m_card = 0; m_target = 0;
  endtask

  task automatic m_cmd(input int op, input int card);
    if (card >= COLS * ROWS) return;
    case (op)
      0: if (m_state[card] == 0) begin m_busy = 1; m_card = card; m_cnt = 0; m_target = 1; end
      1: if (m_state[card] == 1) begin m_busy = 1; m_card = card; m_cnt = 0; m_target = 0; end
      2: if (m_state[card] == 1) m_state[card] = 2;
      default: for (int i = 0; i < 16; i++) m_state[i] = 0;
    endcase
  endtask

  task automatic m_frame();
    if (!m_busy) return;
    if (m_cnt == FLIP_FRAMES - 1) begin
      m_state[m_card] = m_target; m_busy = 0; m_cnt = 0;
    end else m_cnt++;
  endtask

  function automatic logic [3:0] exp_pix(input int h, input int v);
    int dx, dy, c, r, lx, ly, idx, st, k, inset;
    logic [2:0] col;
    dx = h - ORIGIN_X; dy = v - ORIGIN_Y;
    if (dx < 0 || dy < 0) return 4'b0;
    c = dx / PITCH_X; lx = dx % PITCH_X;
    r = dy / PITCH_Y; ly = dy % PITCH_Y;
    if (c >= COLS || r >= ROWS || lx >= CARD_W || ly >= CARD_H) return 4'b0;
    idx = r * COLS + c;
    st = m_state[idx];
    if (m_busy && idx == m_card) begin
      k = (m_cnt < FLIP_FRAMES / 2) ? m_cnt : FLIP_FRAMES - 1 - m_cnt;
      inset = k * (CARD_W / FLIP_FRAMES);
      if (lx < inset || lx > CARD_W - 1 - inset) return 4'b0;
      if (m_cnt >= FLIP_FRAMES / 2) st = m_target;
    end
    case (st)
      0: col = BACK_RGB;
      1: col = rom_pat[3*lx +: 3];
      default: col = MATCH_RGB;
    endcase
    return {1'b1, col};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scan_line(input int v, input int h0, input int h1);
    logic [3:0] e;
    int hh;
    for (int h = h0; h <= h1 + 2; h++) begin
      @(negedge clk);
      if (h >= h0 + 2) begin
        e = exp_q.pop_front();
        hh = h_q.pop_front();
        chk($sformatf("pix_%0d_%0d", hh, v), {28'd0, cardon, rgb}, {28'd0, e});
      end
      if (h <= h1) begin
        hcount = 10'(h); vcount = 10'(v);
        exp_q.push_back(exp_pix(h, v));
        h_q.push_back(h);
      end
    end
  endtask

  task automatic do_frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    m_frame();
  endtask

  task automatic send_cmd(input int op, input int card);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_card = 4'(card);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      @(posedge clk);
      m_cmd(op, card);
    end
    @(negedge clk) cmd_valid = 1'b0;
  endtask

  task automatic flip_done(input int op, input int card);
    send_cmd(op, card);
    while (m_busy) do_frame();
  endtask

  task automatic chk_hs(input string tag);
    chk({tag, "_busy"}, 32'(anim_busy), 32'(m_busy));
    chk({tag, "_ready"}, 32'(cmd_ready), 32'(!m_busy));
  endtask

  task automatic rand_rom();
    for (int i = 0; i < CARD_W * 3; i++) rom_pat[i] = 1'($urandom_range(0, 1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int op, card, nf, h, v;
    rst_n = 1'b0; hcount = '0; vcount = '0; frame_start = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_card = '0;
    for (int i = 0; i < CARD_W; i++) rom_pat[3*i +: 3] = 3'b001;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_cardon", 32'(cardon), 32'd0);
    chk("rst_rom_row", 32'(rom_row), 32'd0);
    chk("rst_busy", 32'(anim_busy), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    // Grid geometry after reset: all backs, gaps dark.
    scan_line(70, 126, 234);
    scan_line(69, 128, 132);
    scan_line(159, 128, 132);
    scan_line(160, 128, 132);
    scan_line(170, 128, 132);
    scan_line(459, 515, 522);

    // Flip up card 0 with an all-001 sprite.
    send_cmd(0, 0);
    chk_hs("flip0_start");
    repeat (3) do_frame();
    chk_hs("flip0_cnt3");
    scan_line(100, 158, 192);
    do_frame();
    scan_line(100, 158, 192);

    // Hold a command across the rest of the animation.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_card = 4'd5;
    for (int i = 0; i < 4; i++) begin
      do_frame();
      if (i < 3) chk($sformatf("hold_ready_%0d", i), 32'(cmd_ready), 32'd0);
    end
    chk("hold_ready_rise", 32'(cmd_ready), 32'd1);
    chk("hold_busy_clear", 32'(anim_busy), 32'd0);
    @(posedge clk);
    m_cmd(1, 5);
    @(negedge clk) cmd_valid = 1'b0;
    chk_hs("hold_after");
    scan_line(100, 126, 224);

    // Matched handling.
    send_cmd(2, 0);
    send_cmd(2, 1);
    scan_line(80, 126, 325);
    send_cmd(0, 0);
    chk_hs("flip_matched");

    // Reset during an animation.
    send_cmd(0, 1);
    repeat (2) do_frame();
    scan_line(80, 280, 280);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("abort_busy", 32'(anim_busy), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_rgb", 32'(rgb), 32'd0);
    chk("abort_cardon", 32'(cardon), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    scan_line(80, 126, 535);

    // Reset-all with a mix of UP and MATCHED cards.
    flip_done(0, 3);
    flip_done(0, 7);
    flip_done(0, 2);
    send_cmd(2, 2);
    scan_line(100, 126, 535);
    send_cmd(3, 0);
    scan_line(100, 126, 535);
    scan_line(200, 126, 535);

    // Card 15 animation with a random sprite.
    rand_rom();
    send_cmd(0, 15);
    repeat (2) do_frame();
    scan_line(400, 426, 524);
    repeat (3) do_frame();
    scan_line(370, 426, 524);
    while (m_busy) do_frame();
    scan_line(370, 426, 524);
    scan_line(459, 426, 524);
    scan_line(460, 428, 432);

    // Randomized commands and pixel probes.
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 3);
      if (op == 3 && $urandom_range(0, 3) != 0) op = 0;
      card = $urandom_range(0, 15);
      if (it % 5 == 0) rand_rom();
      send_cmd(op, card);
      chk_hs($sformatf("rnd_%0d", it));
      if (m_busy) begin
        nf = $urandom_range(1, 8);
        for (int f = 0; f < nf && m_busy; f++) begin
          do_frame();
          v = ORIGIN_Y + (m_card / COLS) * PITCH_Y + $urandom_range(0, CARD_H - 1);
          h = ORIGIN_X + (m_card % COLS) * PITCH_X + $urandom_range(0, CARD_W - 1) - 3;
          scan_line(v, h, h + 6);
        end
        while (m_busy) do_frame();
      end
      for (int p = 0; p < 3; p++) begin
        h = $urandom_range(0, 639);
        v = $urandom_range(0, 479);
        scan_line(v, h, h);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
